// File: rtl/scalar_wb_pkg.sv
// Shared types and default sizes for the scalar register-file writeback queue.
package scalar_wb_pkg;
  localparam int REG_SIZE     = 132;
  localparam int REG_QUANTITY = 16;
  localparam int SEL_BITS     = 4;
  localparam int DEPTH        = 4;

  typedef struct packed {
    logic [SEL_BITS-1:0] dst;
    logic [REG_SIZE-1:0] data;
  } wb_entry_t;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_t;
endpackage

// File: rtl/scalar_wb_queue_fifo.sv
// In-order entry FIFO with a combinational head and per-slot occupancy so the
// parent can build a pending-destination mask.
module wb_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       push_data,
  input  logic                   pop,
  output logic [width-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [depth-1:0]       occupied,
  output logic [depth*width-1:0] slots
);
  localparam int aw = $clog2(depth);

  logic [width-1:0] storage [depth];
  logic [aw-1:0]    rd_ptr_reg;
  logic [aw-1:0]    wr_ptr_reg;
  logic [aw:0]      count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr_reg] <= push_data;
  end

  assign full  = (count_reg == (aw+1)'(depth));
  assign empty = (count_reg == '0);
  assign head  = empty ? '0 : storage[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_slot
      logic [aw-1:0] offset;
      assign offset       = aw'(gi) - rd_ptr_reg;
      assign occupied[gi] = ({1'b0, offset} < count_reg);
      assign slots[gi*width +: width] = storage[gi];
    end
  endgenerate
endmodule

// File: rtl/scalar_wb_queue.sv
// Round-robin ALU/load writeback arbiter feeding an in-order FIFO that drains
// one entry per cycle into the scalar register file write port.
module scalar_wb_queue
  import scalar_wb_pkg::*;
#(
  parameter int regSize     = REG_SIZE,
  parameter int regQuantity = REG_QUANTITY,
  parameter int selBits     = SEL_BITS,
  parameter int depth       = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   aluValid,
  output logic                   aluReady,
  input  logic [selBits-1:0]     aluReg,
  input  logic [regSize-1:0]     aluData,
  input  logic                   memValid,
  output logic                   memReady,
  input  logic [selBits-1:0]     memReg,
  input  logic [regSize-1:0]     memData,
  input  logic                   wrStall,
  output logic                   regWrEn,
  output logic [selBits-1:0]     regToWrite,
  output logic [regSize-1:0]     dataIn,
  output logic [regQuantity-1:0] pendingMask,
  output logic                   full,
  output logic                   empty
);
  localparam int width = selBits + regSize;

  wb_src_t                grant;
  logic                   grant_valid;
  logic                   rr_pri_reg;
  logic                   deq;
  logic                   space;
  logic                   push;
  logic [width-1:0]       push_entry;
  logic [width-1:0]       head;
  logic [depth-1:0]       occupied;
  logic [depth*width-1:0] slots;

  always_comb begin
    grant_valid = aluValid | memValid;
    grant       = SRC_ALU;
    if (aluValid && memValid) grant = rr_pri_reg ? SRC_MEM : SRC_ALU;
    else if (memValid)        grant = SRC_MEM;
  end

  // A retiring head frees a slot in the same cycle, so a full queue still accepts.
  assign deq        = !empty && !wrStall;
  assign space      = !full || deq;
  assign push       = space && grant_valid;
  assign aluReady   = push && (grant == SRC_ALU);
  assign memReady   = push && (grant == SRC_MEM);
  assign push_entry = (grant == SRC_MEM) ? {memReg, memData} : {aluReg, aluData};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           rr_pri_reg <= 1'b0;
    else if (aluValid && memValid && push) rr_pri_reg <= (grant == SRC_ALU);
  end

  wb_fifo #(.width(width), .depth(depth)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (deq),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupied  (occupied),
    .slots     (slots)
  );

  assign regWrEn    = deq;
  assign regToWrite = head[width-1 -: selBits];
  assign dataIn     = head[regSize-1:0];

  generate
    for (genvar gi = 0; gi < regQuantity; gi++) begin : g_mask
      logic [depth-1:0] hit;
      for (genvar gj = 0; gj < depth; gj++) begin : g_hit
        assign hit[gj] = occupied[gj] &&
                         (slots[gj*width + regSize +: selBits] == selBits'(gi));
      end
      assign pendingMask[gi] = |hit;
    end
  endgenerate
endmodule
